// File: rtl/l2_infer_layer_pkg.sv
// Shared types and bus-slicing helpers for the layer-2 inference array.
package l2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StMac,
        StCmp,
        StFire
    } state_e;

    // Threshold/potential width: product width plus headroom for p_s sums.
    function automatic int unsigned thr_width(input int unsigned width,
                                              input int unsigned shift);
        return width + shift + 4;
    endfunction

    // LSB of weight (neuron n, synapse k), both zero-based.
    function automatic int unsigned weight_lsb(input int unsigned n, input int unsigned k,
                                               input int unsigned s,
                                               input int unsigned width);
        return (n * s + k) * width;
    endfunction

    // LSB of threshold/potential for neuron n, zero-based.
    function automatic int unsigned thr_lsb(input int unsigned n, input int unsigned tw);
        return n * tw;
    endfunction

endpackage

// File: rtl/l2_infer_layer_if.sv
// Trainer/sync-facing bus of the layer-2 inference array.
interface l2_infer_layer_if #(
    parameter int unsigned p_width = 8,
    parameter int unsigned p_shift = 8,
    parameter int unsigned p_n     = 10,
    parameter int unsigned p_s     = 5
);
    import l2_pkg::*;

    localparam int unsigned p_thr_width = thr_width(p_width, p_shift);

    logic                         i_trace_tick;
    logic [p_s-1:0]               i_syncout;
    logic [p_n*p_s*p_width-1:0]   i_weights;
    logic [p_n*p_thr_width-1:0]   i_thresholds;
    logic [p_n-1:0]               o_spikeout;
    logic                         o_no_fire;
    logic [p_n*p_thr_width-1:0]   o_sv;
    logic                         o_busy;

    modport master (
        output i_trace_tick, i_syncout, i_weights, i_thresholds,
        input  o_spikeout, o_no_fire, o_sv, o_busy
    );

    modport slave (
        input  i_trace_tick, i_syncout, i_weights, i_thresholds,
        output o_spikeout, o_no_fire, o_sv, o_busy
    );

endinterface

// File: rtl/l2_infer_layer_trace_bank.sv
// Per-synapse decaying traces: a rising sync edge reloads all-ones, a tick
// decrements towards zero.
module l2_trace_bank #(
    parameter int unsigned p_width = 8,
    parameter int unsigned p_s     = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [p_s-1:0]           syncout,
    input  logic                     trace_tick,
    output logic [p_s-1:0]           events,
    output logic [p_s*p_width-1:0]   traces
);

    logic [p_s-1:0]         sync_q;
    logic [p_s-1:0]         sync_prev_q;
    logic [p_s*p_width-1:0] trace_q;

    // Register the sync lines and keep one cycle of history for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q      <= syncout;
            sync_prev_q <= sync_q;
        end
    end

    assign events = sync_q & ~sync_prev_q;

    // Trace update; an event in the same cycle as a tick takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trace_q <= '0;
        end else begin
            for (int unsigned k = 0; k < p_s; k++) begin
                if (events[k]) begin
                    trace_q[k*p_width +: p_width] <= '1;
                end else if (trace_tick && (trace_q[k*p_width +: p_width] != '0)) begin
                    trace_q[k*p_width +: p_width] <= trace_q[k*p_width +: p_width]
                                                     - p_width'(1);
                end
            end
        end
    end

    assign traces = trace_q;

endmodule

// File: rtl/l2_infer_layer.sv
// Layer-2 inference: serial-over-synapse MAC of traces and weights for all
// neurons in parallel, then a winner-take-all spike against thresholds.
module l2_infer_layer
    import l2_pkg::*;
#(
    parameter int unsigned p_width = 8,
    parameter int unsigned p_shift = 8,
    parameter int unsigned p_n     = 10,
    parameter int unsigned p_s     = 5
) (
    input logic             i_clk,
    input logic             i_rst_n,
    l2_infer_layer_if.slave bus
);

    localparam int unsigned p_thr_width = thr_width(p_width, p_shift);
    localparam int unsigned prod_w      = 2 * p_width;
    localparam int unsigned idx_w       = (p_s > 1) ? $clog2(p_s) : 1;

    logic [p_s-1:0]             events;
    logic [p_s*p_width-1:0]     traces;

    state_e                     state_q, state_d;
    logic                       pend_q, pend_d;
    logic                       mac_last;
    logic [idx_w-1:0]           mac_idx_q;
    logic [p_s*p_width-1:0]     trace_snap_q;
    logic [p_n*p_s*p_width-1:0] w_snap_q;
    logic [p_thr_width-1:0]     acc_q [p_n];
    logic [p_thr_width-1:0]     acc_next [p_n];
    logic [prod_w-1:0]          prod [p_n];
    logic [p_thr_width:0]       sum [p_n];
    logic [p_n*p_thr_width-1:0] sv_q;
    logic [p_n-1:0]             win_q, win_d;
    logic                       any_q, any_d;
    logic [p_thr_width-1:0]     best;

    l2_trace_bank #(
        .p_width (p_width),
        .p_s     (p_s)
    ) u_trace_bank (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .syncout    (bus.i_syncout),
        .trace_tick (bus.i_trace_tick),
        .events     (events),
        .traces     (traces)
    );

    assign mac_last = (mac_idx_q == idx_w'(p_s - 1));

    // FSM state and pending-event flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next state; events seen while busy are folded into one follow-up run.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | (|events);
        unique case (state_q)
            StIdle:  if (pend_q || (|events)) state_d = StLatch;
            StLatch: state_d = StMac;
            StMac:   if (mac_last) state_d = StCmp;
            StCmp:   state_d = StFire;
            StFire:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if ((state_q == StIdle) && (state_d == StLatch)) begin
            pend_d = 1'b0;
        end
    end

    // One synapse per MAC cycle, saturating accumulate for every neuron.
    always_comb begin
        for (int unsigned n = 0; n < p_n; n++) begin
            prod[n] = prod_w'(w_snap_q[weight_lsb(n, 32'(mac_idx_q), p_s, p_width) +: p_width])
                    * prod_w'(trace_snap_q[32'(mac_idx_q) * p_width +: p_width]);
            sum[n]      = {1'b0, acc_q[n]} + (p_thr_width + 1)'(prod[n]);
            acc_next[n] = sum[n][p_thr_width] ? '1 : sum[n][p_thr_width-1:0];
        end
    end

    // Winner: largest eligible potential, strict '>' keeps the lowest index on ties.
    always_comb begin
        win_d = '0;
        any_d = 1'b0;
        best  = '0;
        for (int unsigned n = 0; n < p_n; n++) begin
            if ((acc_q[n] >= bus.i_thresholds[thr_lsb(n, p_thr_width) +: p_thr_width])
                && (!any_d || (acc_q[n] > best))) begin
                any_d    = 1'b1;
                best     = acc_q[n];
                win_d    = '0;
                win_d[n] = 1'b1;
            end
        end
    end

    // Datapath: snapshot in LATCH, accumulate in MAC, publish result in CMP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mac_idx_q    <= '0;
            trace_snap_q <= '0;
            w_snap_q     <= '0;
            sv_q         <= '0;
            win_q        <= '0;
            any_q        <= 1'b0;
            for (int unsigned n = 0; n < p_n; n++) acc_q[n] <= '0;
        end else begin
            unique case (state_q)
                StLatch: begin
                    trace_snap_q <= traces;
                    w_snap_q     <= bus.i_weights;
                    mac_idx_q    <= '0;
                    for (int unsigned n = 0; n < p_n; n++) acc_q[n] <= '0;
                end
                StMac: begin
                    mac_idx_q <= mac_idx_q + idx_w'(1);
                    for (int unsigned n = 0; n < p_n; n++) acc_q[n] <= acc_next[n];
                end
                StCmp: begin
                    win_q <= win_d;
                    any_q <= any_d;
                    for (int unsigned n = 0; n < p_n; n++) begin
                        sv_q[n*p_thr_width +: p_thr_width] <= acc_q[n];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_spikeout = (state_q == StFire) ? win_q : '0;
    assign bus.o_no_fire  = (state_q == StFire) && !any_q;
    assign bus.o_sv       = sv_q;
    assign bus.o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_l2_infer_layer.sv
// Directed bench for l2_infer_layer with a cycle-level reference model.
module tb_l2_infer_layer;
    import l2_pkg::*;

    localparam int W  = 8;
    localparam int SH = 8;
    localparam int N  = 10;
    localparam int S  = 5;
    localparam int TW = int'(thr_width(W, SH));
    localparam longint SatMax = (longint'(1) << TW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    l2_infer_layer_if #(.p_width(W), .p_shift(SH), .p_n(N), .p_s(S)) bus ();

    l2_infer_layer #(
        .p_width (W),
        .p_shift (SH),
        .p_n     (N),
        .p_s     (S)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [S-1:0]  m_s1 = '0;
    logic [S-1:0]  m_s2 = '0;
    logic [S-1:0]  m_ev = '0;
    int            m_phase = -1;
    logic          m_pend = 1'b0;
    int            m_trace [S] = '{default: 0};
    int            m_tsnap [S] = '{default: 0};
    int            m_wsnap [N][S];
    logic [TW-1:0] m_sv [N] = '{default: '0};
    logic [N-1:0]  m_spike = '0;
    logic          m_nofire = 1'b0;
    logic          m_busy = 1'b0;
    longint        m_acc, m_best, m_thr;
    int            m_win;

    // Phase counts edges since the run was accepted: snapshot at 1, result at S+2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_phase = -1; m_pend = 1'b0;
            m_spike = '0; m_nofire = 1'b0; m_busy = 1'b0;
            for (int k = 0; k < S; k++) m_trace[k] = 0;
            for (int n = 0; n < N; n++) m_sv[n] = '0;
        end else begin
            m_ev = m_s1 & ~m_s2;
            m_s2 = m_s1;
            m_s1 = bus.i_syncout;
            m_spike = '0;
            m_nofire = 1'b0;
            if (m_phase < 0) begin
                if (m_pend || (m_ev != '0)) begin
                    m_phase = 0;
                    m_pend = 1'b0;
                end
            end else begin
                if (m_ev != '0) m_pend = 1'b1;
                m_phase++;
                if (m_phase == 1) begin
                    for (int k = 0; k < S; k++) m_tsnap[k] = m_trace[k];
                    for (int n = 0; n < N; n++)
                        for (int k = 0; k < S; k++)
                            m_wsnap[n][k] = int'(bus.i_weights[(n*S+k)*W +: W]);
                end else if (m_phase == S + 2) begin
                    m_win = -1;
                    m_best = 0;
                    for (int n = 0; n < N; n++) begin
                        m_acc = 0;
                        for (int k = 0; k < S; k++)
                            m_acc += longint'(m_wsnap[n][k]) * longint'(m_tsnap[k]);
                        if (m_acc > SatMax) m_acc = SatMax;
                        m_sv[n] = TW'(m_acc);
                        m_thr = longint'(bus.i_thresholds[n*TW +: TW]);
                        if (m_acc >= m_thr && (m_win < 0 || m_acc > m_best)) begin
                            m_win = n;
                            m_best = m_acc;
                        end
                    end
                    if (m_win < 0) m_nofire = 1'b1;
                    else m_spike[m_win] = 1'b1;
                end else if (m_phase == S + 3) begin
                    m_phase = -1;
                end
            end
            for (int k = 0; k < S; k++) begin
                if (m_ev[k]) m_trace[k] = (1 << W) - 1;
                else if (bus.i_trace_tick && m_trace[k] > 0) m_trace[k]--;
            end
            m_busy = (m_phase >= 0);
        end
    end

    // Every-cycle comparison against the model, on the inactive edge.
    logic [N*TW-1:0] exp_sv;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int n = 0; n < N; n++) exp_sv[n*TW +: TW] = m_sv[n];
            check("cyc_spikeout", bus.o_spikeout, m_spike);
            check("cyc_no_fire", bus.o_no_fire, m_nofire);
            check("cyc_busy", bus.o_busy, m_busy);
            check("cyc_sv", bus.o_sv, exp_sv);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input int hot, input logic [W-1:0] hot_val,
                               input logic [W-1:0] other);
        for (int n = 0; n < N; n++)
            for (int k = 0; k < S; k++)
                bus.i_weights[(n*S+k)*W +: W] = (n == hot) ? hot_val : other;
    endtask

    task automatic set_thresholds(input logic [TW-1:0] thr);
        for (int n = 0; n < N; n++) bus.i_thresholds[n*TW +: TW] = thr;
    endtask

    task automatic tick_n(input int n);
        bus.i_trace_tick = 1'b1;
        cycles(n);
        bus.i_trace_tick = 1'b0;
    endtask

    // Raise sync bits, return edges from E0 to the fire cycle; lat stays 0 without a fire.
    task automatic run_event(input logic [S-1:0] bits, input bit clobber, output int lat,
                             output logic [N-1:0] spk, output logic nf);
        bus.i_syncout = bits;
        cycles(1);
        lat = 0;
        spk = '0;
        nf = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            cycles(1);
            if (clobber && c == 3) bus.i_weights = '0;
            if (bus.o_spikeout != '0 || bus.o_no_fire) begin
                lat = c;
                spk = bus.o_spikeout;
                nf = bus.o_no_fire;
                break;
            end
        end
    endtask

    int           lat, fires, first, second;
    logic [N-1:0] spk;
    logic         nf;

    initial begin
        bus.i_trace_tick = 1'b0;
        bus.i_syncout = '0;
        set_weights(-1, 8'hff, 8'hff);
        set_thresholds(20'h0ff00);
        cycles(3);
        check("rst_spikeout", bus.o_spikeout, 0);
        check("rst_no_fire", bus.o_no_fire, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_sv", bus.o_sv, 0);
        rst_n = 1'b1;
        cycles(1);
        tick_n(8);
        cycles(2);
        check("tick_idle_busy", bus.o_busy, 0);

        // Single trace: 255*255 below threshold.
        run_event(5'b00001, 1'b0, lat, spk, nf);
        check("t1_latency", lat, 8);
        check("t1_no_fire", nf, 1);
        check("t1_spikeout", spk, 0);
        check("t1_sv0", bus.o_sv[0 +: TW], 20'h0fe01);
        check("t1_sv9", bus.o_sv[9*TW +: TW], 20'h0fe01);
        bus.i_syncout = '0;
        cycles(3);

        // Two traces, all neurons tie: lowest index wins.
        run_event(5'b00011, 1'b0, lat, spk, nf);
        check("t2_latency", lat, 8);
        check("t2_spikeout", spk, 10'b0000000001);
        check("t2_no_fire", nf, 0);
        check("t2_sv5", bus.o_sv[5*TW +: TW], 20'h1fc02);
        bus.i_syncout = '0;
        set_weights(3, 8'hff, 8'h80);
        cycles(3);

        // Neuron 3 wins; weights cleared mid-MAC must not matter.
        run_event(5'b00011, 1'b1, lat, spk, nf);
        check("t3_latency", lat, 8);
        check("t3_spikeout", spk, 10'b0000001000);
        check("t3_sv3", bus.o_sv[3*TW +: TW], 20'h1fc02);
        check("t3_sv0", bus.o_sv[0 +: TW], 20'h0ff00);
        set_weights(-1, 8'hff, 8'hff);
        bus.i_syncout = '0;
        tick_n(256);

        // Decayed trace: 255*(245+255).
        run_event(5'b00001, 1'b0, lat, spk, nf);
        check("t4a_no_fire", nf, 1);
        tick_n(10);
        run_event(5'b00011, 1'b0, lat, spk, nf);
        check("t4_sv0", bus.o_sv[0 +: TW], 20'h1f20c);
        check("t4_spikeout", spk, 10'b0000000001);
        bus.i_syncout = '0;
        cycles(3);

        // Event while busy: exactly one follow-up run.
        bus.i_syncout = 5'b00100;
        cycles(1);
        fires = 0; first = 0; second = 0;
        for (int c = 1; c <= 40; c++) begin
            cycles(1);
            if (bus.o_spikeout != '0 || bus.o_no_fire) begin
                fires++;
                if (fires == 1) first = c;
                else if (fires == 2) second = c;
            end
            if (c == 2) bus.i_syncout = 5'b01100;
        end
        check("t5_fire_count", fires, 2);
        check("t5_first_lat", first, 8);
        check("t5_gap", second - first, S + 4);
        bus.i_syncout = '0;
        cycles(3);

        // Reset mid-run with a pending event: nothing fires afterwards.
        bus.i_syncout = 5'b10000;
        cycles(1);
        cycles(2);
        bus.i_syncout = 5'b11000;
        cycles(2);
        rst_n = 1'b0;
        #1;
        check("t6_busy_drop", bus.o_busy, 0);
        check("t6_spikeout", bus.o_spikeout, 0);
        check("t6_no_fire", bus.o_no_fire, 0);
        bus.i_syncout = '0;
        cycles(2);
        rst_n = 1'b1;
        fires = 0;
        for (int c = 0; c < 30; c++) begin
            cycles(1);
            if (bus.o_spikeout != '0 || bus.o_no_fire) fires++;
        end
        check("t6_no_fires", fires, 0);
        check("t6_idle", bus.o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
